// File: rtl/sdram_burst_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the SDRAM burst arbiter.
// master = arbiter view, slave = requesters + SDRAM controller view.
interface sdram_burst_arbiter_if #(
  parameter int AddressWidth = 24,
  parameter int WordLength   = 16
);
  logic                    i_wr_req;
  logic [AddressWidth-1:0] i_wr_addr;
  logic [WordLength-1:0]   i_wr_data;
  logic                    o_wr_grant;
  logic                    o_wr_pop;
  logic                    o_wr_done;

  logic                    i_rd_req;
  logic [AddressWidth-1:0] i_rd_addr;
  logic                    o_rd_grant;
  logic                    o_rd_valid;
  logic [WordLength-1:0]   o_rd_data;
  logic                    o_rd_done;

  logic                    o_sdram_enable;
  logic                    o_sdram_rw;
  logic [AddressWidth-1:0] o_sdram_addr;
  logic [WordLength-1:0]   o_sdram_data;
  logic                    i_sdram_busy;
  logic                    i_sdram_valid_wr;
  logic                    i_sdram_valid_rd;
  logic [WordLength-1:0]   i_sdram_data;

  logic                    o_error;

  modport master (
    input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
           i_sdram_busy, i_sdram_valid_wr, i_sdram_valid_rd, i_sdram_data,
    output o_wr_grant, o_wr_pop, o_wr_done, o_rd_grant, o_rd_valid, o_rd_data, o_rd_done,
           o_sdram_enable, o_sdram_rw, o_sdram_addr, o_sdram_data, o_error
  );

  modport slave (
    output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
           i_sdram_busy, i_sdram_valid_wr, i_sdram_valid_rd, i_sdram_data,
    input  o_wr_grant, o_wr_pop, o_wr_done, o_rd_grant, o_rd_valid, o_rd_data, o_rd_done,
           o_sdram_enable, o_sdram_rw, o_sdram_addr, o_sdram_data, o_error
  );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Grants whole SDRAM bursts to the camera write path or the compressor read path.
// Writes win by default; a starvation counter forces a read after StarveLimit write grants.
module sdram_burst_arbiter #(
  parameter int AddressWidth  = 24,
  parameter int WordLength    = 16,
  parameter int BurstLength   = 8,
  parameter int StarveLimit   = 4,
  parameter int TimeoutCycles = 1024
) (
  input logic CLK,
  input logic RST,
  sdram_burst_arbiter_if.master bus
);
  localparam int BW = $clog2(BurstLength);
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam int SW = $clog2(StarveLimit + 1);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_DATA, RD_ISSUE, RD_DATA} state_t;

  state_t                  state, state_n;
  logic [BW-1:0]           beat;
  logic [TW-1:0]           to_cnt;
  logic [SW-1:0]           starve;
  logic [AddressWidth-1:0] addr_q;
  logic [WordLength-1:0]   rd_data_q;
  logic                    wr_done_q, rd_valid_q, rd_done_q, error_q;
  logic                    grant_wr, grant_rd, wr_beat, rd_beat, last_beat, timed_out, abort;

  // The write done pulse lands in IDLE; holding off grants then keeps done -> idle -> grant spacing.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE && !RST && !bus.i_sdram_busy && !wr_done_q) begin
      if (bus.i_wr_req && (!bus.i_rd_req || starve != SW'(StarveLimit))) grant_wr = 1'b1;
      else if (bus.i_rd_req)                                              grant_rd = 1'b1;
    end
  end

  assign wr_beat   = (state == WR_DATA) && bus.i_sdram_valid_wr;
  assign rd_beat   = (state == RD_DATA) && bus.i_sdram_valid_rd && !rd_done_q;
  assign last_beat = (beat == BW'(BurstLength - 1));
  assign timed_out = (to_cnt == TW'(TimeoutCycles));
  assign abort     = timed_out && (((state == WR_DATA) && !wr_beat) ||
                                   ((state == RD_DATA) && !rd_beat && !rd_done_q));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (grant_wr) state_n = WR_ISSUE;
                else if (grant_rd) state_n = RD_ISSUE;
      WR_ISSUE: if (!bus.i_sdram_busy) state_n = WR_DATA;
      WR_DATA:  if ((wr_beat && last_beat) || abort) state_n = IDLE;
      RD_ISSUE: if (!bus.i_sdram_busy) state_n = RD_DATA;
      RD_DATA:  if (rd_done_q || abort) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      beat       <= '0;
      to_cnt     <= '0;
      starve     <= '0;
      addr_q     <= '0;
      rd_data_q  <= '0;
      wr_done_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state      <= state_n;
      wr_done_q  <= wr_beat && last_beat;
      rd_valid_q <= rd_beat;
      rd_done_q  <= rd_beat && last_beat;
      if (rd_beat) rd_data_q <= bus.i_sdram_data;

      if (grant_wr)      addr_q <= bus.i_wr_addr;
      else if (grant_rd) addr_q <= bus.i_rd_addr;

      if (grant_rd)
        starve <= '0;
      else if (grant_wr && bus.i_rd_req && starve != SW'(StarveLimit))
        starve <= starve + 1'b1;

      if (state == IDLE)           beat <= '0;
      else if (wr_beat || rd_beat) beat <= beat + 1'b1;

      // Watchdog restarts on issue and on every beat; it parks at the limit until the next issue.
      if (state == WR_ISSUE || state == RD_ISSUE || wr_beat || rd_beat)
        to_cnt <= '0;
      else if ((state == WR_DATA || state == RD_DATA) && !timed_out)
        to_cnt <= to_cnt + 1'b1;

      if (abort) error_q <= 1'b1;
    end
  end

  assign bus.o_wr_grant     = grant_wr;
  assign bus.o_rd_grant     = grant_rd;
  assign bus.o_wr_pop       = wr_beat && !RST;
  assign bus.o_wr_done      = wr_done_q;
  assign bus.o_rd_valid     = rd_valid_q;
  assign bus.o_rd_data      = rd_data_q;
  assign bus.o_rd_done      = rd_done_q;
  assign bus.o_sdram_enable = (state == WR_ISSUE || state == RD_ISSUE) && !bus.i_sdram_busy && !RST;
  assign bus.o_sdram_rw     = (state == RD_ISSUE) && !RST;
  assign bus.o_sdram_addr   = addr_q;
  assign bus.o_sdram_data   = (state == WR_DATA && !RST) ? bus.i_wr_data : '0;
  assign bus.o_error        = error_q;
endmodule

// File: doc/sdram_burst_arbiter.md
# sdram_burst_arbiter

Shares the single SDRAM controller between two requesters in the capture path: the write side, which drains camera pixels from the PCLK→CLK FIFO, and the read side, which fetches the previous frame's row for the compressor. It grants whole bursts, one requester at a time, and issues the enable, direction and address to the controller. It also steers burst data in both directions. Writes have priority so the camera FIFO never overflows, and a starvation limit guarantees forward progress for reads.

## Interface
- AddressWidth, 24, SDRAM burst start address width (bank+row+col)
- WordLength, 16, SDRAM word / pixel width
- BurstLength, 8, words per burst, power of two ≥2
- StarveLimit, 4, consecutive write grants allowed while a read is pending, ≥1
- TimeoutCycles, 1024, max cycles between issue/beats before abort
- CLK  in  1  system clock; single clock domain
- RST  in  1  synchronous, active-high reset
- i_wr_req / i_wr_addr / i_wr_data  in  1 / AddressWidth / WordLength  write burst request, start address, FWFT head word
- o_wr_grant / o_wr_pop / o_wr_done  out  1 / 1 / 1  grant pulse, pop one word, burst-complete pulse
- i_rd_req / i_rd_addr  in  1 / AddressWidth  read burst request, start address
- o_rd_grant / o_rd_valid / o_rd_data / o_rd_done  out  1 / 1 / WordLength / 1  grant pulse, read word strobe, word, burst-complete pulse
- o_sdram_enable / o_sdram_rw / o_sdram_addr / o_sdram_data  out  1 / 1 / AddressWidth / WordLength  controller command (rw: 1=read, 0=write), address, write data
- i_sdram_busy / i_sdram_valid_wr / i_sdram_valid_rd / i_sdram_data  in  1 / 1 / 1 / WordLength  controller status, write-beat accept, read-beat strobe, read data
- o_error  out  1  sticky timeout flag, cleared only by RST

## Operation
- States: IDLE, WR_ISSUE, WR_DATA, RD_ISSUE, RD_DATA.
- Requests are sampled only in IDLE with i_sdram_busy=0. A requester holds req and addr stable until its grant.
- Arbitration in IDLE:
  - only wr_req: grant write.
  - only rd_req: grant read.
  - both: grant write unless starve_cnt==StarveLimit, then grant read.
- starve_cnt: +1 on each write grant while i_rd_req=1, saturating at StarveLimit. Cleared on a read grant.
- Grant cycle: pulse o_*_grant for 1 cycle, latch the address, go to *_ISSUE.
- *_ISSUE: o_sdram_enable=1 and o_sdram_rw valid for exactly one cycle, with o_sdram_addr = latched address. Next state is *_DATA.
- WR_DATA:
  - o_sdram_data = i_wr_data (combinational).
  - o_wr_pop = i_sdram_valid_wr (combinational).
  - beat counter counts accepted beats. On beat BurstLength-1: o_wr_done pulses the next cycle and the state goes to IDLE.
- RD_DATA:
  - o_rd_data is registered from i_sdram_data on i_sdram_valid_rd, and o_rd_valid is asserted the next cycle.
  - o_rd_done is coincident with o_rd_valid of the last word.
  - IDLE is entered the cycle after.
- Beat counter width is log2(BurstLength). It wraps to 0 at burst end.
- Timeout: a counter resets on issue and on each beat. If it reaches TimeoutCycles in *_DATA, set o_error, abort to IDLE, and emit no done pulse. Words already popped are lost.
- Beats arriving while in IDLE or in the wrong direction are ignored (no pop, no valid).

## Timing
- Reset values: all outputs 0, o_sdram_addr=0, o_sdram_data=0, state IDLE, all counters 0.
- RST mid-burst: returns to IDLE the next cycle, with no done pulse and no further pops.
- Grant-to-enable latency: enable is asserted the cycle after the grant pulse. If i_sdram_busy rises before issue, stay in *_ISSUE holding enable=0 until busy=0.
- Minimum gap between two bursts: done → IDLE → grant, i.e. 2 cycles.
- Read output latency: 1 cycle after each i_sdram_valid_rd.
- Write path: zero-latency combinational pop/data.

## Test plan
- Write only: wr_req with addr 0x000100, controller accepts 8 beats → one grant, enable=1 with rw=0 and addr=0x000100 for one cycle, exactly 8 pops, data matches FIFO order, done pulse once.
- Read only: rd_req with addr 0x000200, controller returns 0xA0..0xA7 → 8 rd_valid pulses, each 1 cycle after valid_rd, data 0xA0..0xA7, done with the 8th valid.
- Both requesting continuously, StarveLimit=4 → grant order W,W,W,W,R,W,W,W,W,R…
- Simultaneous request arriving while i_sdram_busy=1 → no grant until busy=0, then the write grant is issued first.
- Controller stalls after 3 write beats for TimeoutCycles → o_error=1 and return to IDLE. No done pulse, o_error stays high, and a following read burst still completes.
- RST asserted on read beat 4 → all outputs 0 next cycle. A new write after reset completes normally, and starve_cnt is 0.
